// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter
// Shares one single-port synchronous ROM (1-cycle registered read) between
// NREQ requesters. At most one read is issued per cycle. Each read is tagged
// with the id of its requester and its data is buffered in a DEPTH-entry
// response FIFO with valid/ready handshaking.
//
// Ports:
//   clk        single clock, all state on posedge
//   rst        synchronous, active-high reset
//   req        per-requester request, held with a stable address until granted
//   req_addr   flattened request addresses, requester i at [i*AW +: AW]
//   gnt        one-hot grant (combinational); the request is consumed that cycle
//   rom_en     ROM enable, equals |gnt
//   rom_addr   address of the granted requester, 0 when idle
//   rom_data   ROM read data, valid the cycle after rom_en
//   rsp_valid  response FIFO non-empty
//   rsp_ready  consumer takes the head entry when rsp_valid & rsp_ready
//   rsp_id     requester id of the head entry (0 when empty)
//   rsp_data   data of the head entry (0 when empty)
//
// Build option:
//   ARB_FIXED_PRIORITY_EN  defined   -> fixed priority, lowest index wins
//                          undefined -> round-robin from rr_ptr (default)

module rom_access_arbiter #(
  parameter int NREQ  = 4,
  parameter int AW    = 5,
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*AW-1:0]      req_addr,
  output logic [NREQ-1:0]         gnt,
  output logic                    rom_en,
  output logic [AW-1:0]           rom_addr,
  input  logic [DW-1:0]           rom_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [DW-1:0]           rsp_data
);

  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic            inflight;
  logic [IW-1:0]   id_q;
  logic [IW-1:0]   win;
  logic            found;
  logic [IW:0]     idx;
  logic            can_issue;
  logic            push;
  logic            pop;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [IW-1:0]   mem_id   [DEPTH];
  logic [DW-1:0]   mem_data [DEPTH];

`ifndef ARB_FIXED_PRIORITY_EN
  logic [IW-1:0]   rr_ptr;
`endif

  // Credit counts the FIFO plus the read already in flight. A pop in the
  // same cycle is deliberately not credited, so the issue path never depends
  // on rsp_ready.
  assign can_issue = ({1'b0, count} + {{CW{1'b0}}, inflight}) < (CW+1)'(DEPTH);

  // NOTE: every output of this block gets a default before the loop so no
  // path leaves a value unassigned, which would infer a latch.
  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    if (!rst && can_issue) begin
      for (int k = 0; k < NREQ; k++) begin
        // NOTE: blocking assignments here; the loop reads its own partial
        // result (found) within the same evaluation.
`ifdef ARB_FIXED_PRIORITY_EN
        idx = (IW+1)'(k);
`else
        idx = {1'b0, rr_ptr} + (IW+1)'(k);
        if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
`endif
        if (!found && req[idx[IW-1:0]]) begin
          found = 1'b1;
          win   = idx[IW-1:0];
        end
      end
      if (found) gnt[win] = 1'b1;
    end
  end

  assign rom_en   = |gnt;
  assign rom_addr = rom_en ? req_addr[win*AW +: AW] : '0;

  // rom_data is only captured while a read is in flight, so an undriven ROM
  // output can never enter the FIFO.
  assign push      = inflight;
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_id    = rsp_valid ? mem_id[rd_ptr]   : '0;
  assign rsp_data  = rsp_valid ? mem_data[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      id_q     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= rom_en;
      if (rom_en) id_q <= win;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: the storage array is not reset; count gates every read of it, so
  // stale contents are never visible and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_id[wr_ptr]   <= id_q;
      mem_data[wr_ptr] <= rom_data;
    end
  end

`ifndef ARB_FIXED_PRIORITY_EN
  always_ff @(posedge clk) begin
    if (rst)         rr_ptr <= '0;
    else if (rom_en) rr_ptr <= (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
  end
`endif

  // The credit check must make a push into a full FIFO impossible.
  push_when_full: assert property (@(posedge clk) disable iff (rst)
                                   push |-> (count < CW'(DEPTH)));

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Self-checking bench for rom_access_arbiter. A 32x8 registered ROM model
// drives rom_data; a scoreboard queues (id, data) at every grant and
// compares it against each accepted response.

module tb_rom_access_arbiter;

  localparam int NREQ  = 4;
  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int IW    = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]   gnt;
  logic              rom_en;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_data;

  logic [AW-1:0]     tb_addr [NREQ];
  logic [DW-1:0]     rom_mem [32];
  logic [NREQ-1:0]   pending;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   gseq[$];
  int   gcyc[$];
  int   cyc;
  int   checks;
  int   errors;
  bit   seen46;

  rom_access_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .gnt       (gnt),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  for (genvar i = 0; i < NREQ; i++) begin : g_addr
    assign req_addr[i*AW +: AW] = tb_addr[i];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM model: registered read, undefined output when disabled.
  initial begin
    for (int a = 0; a < 32; a++) rom_mem[a] = 8'(a + 100);
    rom_mem[0]  = 8'd4;
    rom_mem[1]  = 8'd3;
    rom_mem[2]  = 8'd9;
    rom_mem[3]  = 8'd10;
    rom_mem[10] = 8'd45;
    rom_mem[31] = 8'd46;
  end

  always @(posedge clk) rom_data <= rom_en ? rom_mem[rom_addr] : 'x;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: push at grant, pop and compare at handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      check("gnt_onehot", 32'($countones(gnt) <= 1), 1);
      if (!rom_en) check("rom_addr_idle", rom_addr, 0);
      for (int i = 0; i < NREQ; i++)
        if (gnt[i]) exp_q.push_back('{id: IW'(i), data: rom_mem[tb_addr[i]]});
      if (rsp_valid && rsp_data == 8'd46) seen46 = 1'b1;
      if (rsp_valid && rsp_ready) begin
        check("sb_has_entry", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          rsp_t e;
          e = exp_q.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_data", rsp_data, e.data);
        end
      end
      if (!rsp_valid) begin
        check("rsp_data_idle", rsp_data, 0);
        check("rsp_id_idle", rsp_id, 0);
      end
    end
  end

  // Called just after the negedge: log grants and retire granted requests.
  task automatic sample_grants();
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        gseq.push_back(i);
        gcyc.push_back(cyc);
      end
    pending = pending & ~gnt;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    req = pending;
  endtask

  task automatic cycle();
    @(negedge clk);
    sample_grants();
    advance();
  endtask

  task automatic run_pending(input int budget);
    int n = 0;
    while (pending != 0 && n < budget) begin
      cycle();
      n++;
    end
    check("grant_budget", 32'(pending), 0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < budget) begin
      advance();
      n++;
    end
    check("drain_budget", 32'(exp_q.size() != 0 || rsp_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int ng;
    checks = 0; errors = 0; cyc = 0; seen46 = 1'b0;
    rst = 1'b1; rsp_ready = 1'b1; pending = '0;
    for (int i = 0; i < NREQ; i++) tb_addr[i] = AW'(i);
    req = 4'b1111;

    // Reset: requests present but nothing may be granted.
    @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_rom_en", rom_en, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // All requesters, addresses 0..3: grants in order 0,1,2,3.
    gseq.delete(); gcyc.delete();
    pending = 4'b1111; req = pending;
    run_pending(30);
    check("all_ngrants", gseq.size(), 4);
    for (int i = 0; i < gseq.size(); i++) check("all_order", gseq[i], i);
    if (gcyc.size() >= 2) check("all_back_to_back", gcyc[1] - gcyc[0], 1);
    drain(30);

    // Next pass begins with requester 0.
    gseq.delete();
    pending = 4'b1111; req = pending;
    @(negedge clk);
    check("rr_restart", gnt, 4'b0001);
    sample_grants();
    advance();
    run_pending(30);
    drain(30);

    // Single request: addr 10 -> data 45 from requester 0 at T+2.
    tb_addr[0] = 5'd10;
    pending = 4'b0001; req = pending;
    @(negedge clk);
    check("single_gnt", gnt, 4'b0001);
    check("single_rom_en", rom_en, 1);
    check("single_rom_addr", rom_addr, 10);
    check("single_valid_t0", rsp_valid, 0);
    sample_grants();
    advance();
    @(negedge clk);
    check("single_valid_t1", rsp_valid, 0);
    advance();
    @(negedge clk);
    check("single_valid_t2", rsp_valid, 1);
    check("single_id", rsp_id, 0);
    check("single_data", rsp_data, 45);
    advance();
    drain(20);

    // Backpressure: FIFO + credit allow exactly two outstanding reads.
    for (int i = 0; i < NREQ; i++) tb_addr[i] = AW'(i);
    rsp_ready = 1'b0;
    gseq.delete();
    pending = 4'b1111; req = pending;
    ng = 0;
    repeat (6) begin
      @(negedge clk);
      if (gnt != 0) ng++;
      sample_grants();
      advance();
    end
    check("bp_grants", ng, 2);
    @(negedge clk);
    check("bp_gnt_stall", gnt, 0);
    check("bp_rom_en_stall", rom_en, 0);
    check("bp_rsp_valid", rsp_valid, 1);
    advance();
    rsp_ready = 1'b1;
    run_pending(30);
    check("bp_total_grants", gseq.size(), 4);
    drain(30);

    // Withdrawal: requester 2 asks while credit is exhausted, then drops.
    rsp_ready = 1'b0;
    gseq.delete();
    pending = 4'b0011; req = pending;
    run_pending(10);
    pending = 4'b0100; req = pending;
    repeat (3) begin
      @(negedge clk);
      check("wd_gnt_blocked", gnt, 0);
      check("wd_rom_en_blocked", rom_en, 0);
      advance();
    end
    pending = 4'b0000; req = pending;
    rsp_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("wd_gnt_idle", gnt, 0);
      advance();
    end
    drain(20);
    @(negedge clk);
    check("wd_rsp_valid", rsp_valid, 0);
    check("wd_rsp_data", rsp_data, 0);
    check("wd_grants", gseq.size(), 2);
    advance();

    // Reset one cycle after a grant to addr 31: that read is discarded.
    seen46 = 1'b0;
    tb_addr[0] = 5'd31;
    pending = 4'b0001; req = pending;
    @(negedge clk);
    check("mid_gnt", gnt, 4'b0001);
    check("mid_rom_addr", rom_addr, 31);
    sample_grants();
    advance();
    rst = 1'b1;
    tb_addr[0] = 5'd10;
    pending = 4'b1111; req = pending;
    @(negedge clk);
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_rom_en", rom_en, 0);
    check("mid_rst_valid", rsp_valid, 0);
    advance();
    @(negedge clk);
    check("mid_rst_valid2", rsp_valid, 0);
    advance();
    rst = 1'b0;
    @(negedge clk);
    check("mid_first_gnt", gnt, 4'b0001);
    sample_grants();
    advance();
    run_pending(30);
    drain(30);
    check("mid_no_46", seen46, 0);

    // Two contenders: requesters 1 and 2.
    tb_addr[1] = 5'd1;
    tb_addr[2] = 5'd2;
    gseq.delete();
`ifdef ARB_FIXED_PRIORITY_EN
    pending = 4'b0110; req = pending;
    @(negedge clk);
    check("fp_first", gnt, 4'b0010);
    advance();
    repeat (2) begin
      @(negedge clk);
      check("fp_not_req2", gnt[2], 0);
      advance();
    end
    drain(20);
    pending = 4'b0100; req = pending;
    run_pending(10);
    check("fp_req2_served", gseq.size(), 1);
`else
    pending = 4'b0110; req = pending;
    run_pending(20);
    check("rr_pair_n", gseq.size(), 2);
    if (gseq.size() == 2) begin
      check("rr_pair_0", gseq[0], 1);
      check("rr_pair_1", gseq[1], 2);
    end
`endif
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
